// File: rtl/usb_prot_pkg.sv
// Shared constants, state encoding and CRC helper for the USB protocol framer.
package usb_prot_pkg;

  localparam logic [7:0] SYNC0     = 8'h5E;
  localparam logic [7:0] SYNC1     = 8'h4D;
  localparam logic [7:0] CRC_POLY  = 8'h07;
  localparam int         HDR_BYTES = 6;
  localparam int         LEN_W     = 16;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    BODY = 3'd2,
    TAIL = 3'd3,
    DONE = 3'd4
  } enc_state_e;

  // One byte of CRC8 (poly 0x07, MSB first, no reflection).
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] b);
    logic [7:0] c;
    c = crc ^ b;
    for (int i = 0; i < 8; i++)
      c = c[7] ? ({c[6:0], 1'b0} ^ CRC_POLY) : {c[6:0], 1'b0};
    return c;
  endfunction

endpackage

// File: rtl/usb_prot_encoder_crc8.sv
// crc8_ccitt: single-byte CRC8 stage, chained by the framer.
module crc8_ccitt
  import usb_prot_pkg::*;
(
  input  logic [7:0] crc_in,
  input  logic [7:0] din,
  output logic [7:0] crc_out
);

  assign crc_out = crc8_byte(crc_in, din);

endmodule

// File: rtl/usb_prot_encoder.sv
// usb_prot_encoder: transmit framer producing 5E 4D addr lenH lenL hcrc payload dcrc,
// packed MSB-first into 32-bit words with a byte-count qualifier.
// Optional macro USB_ENC_CRC_INJ_EN adds crc_inj_i, which inverts the emitted dcrc.
module usb_prot_encoder
  import usb_prot_pkg::*;
#(
  parameter logic [LEN_W-1:0] MAX_LEN  = 16'd4096,
  parameter logic [7:0]       CRC_INIT = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [7:0]  addr_i,
  input  logic [15:0] len_i,
  input  logic [31:0] dat_i,
  input  logic        dat_vld_i,
  output logic        dat_rdy_o,
  output logic        op_o,
  output logic [31:0] op_dat_o,
  output logic [2:0]  op_be_o,
  input  logic        op_rdy_i,
`ifdef USB_ENC_CRC_INJ_EN
  input  logic        crc_inj_i,
`endif
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);

  // CRC state after the two constant sync bytes.
  localparam logic [7:0] SYNC_CRC = crc8_byte(crc8_byte(CRC_INIT, SYNC0), SYNC1);

  enc_state_e       state;
  logic [LEN_W-1:0] rem;     // payload bytes not yet consumed
  logic [15:0]      carry;   // leftover bytes, left-aligned
  logic [1:0]       ncarry;  // valid carry bytes once the payload is exhausted
  logic [7:0]       crc_q;   // running data CRC
  logic             inj_q;

  // Header CRC: addr, lenH, lenL chained onto the sync CRC.
  logic [7:0] hdr_b [3];
  logic [7:0] hc    [4];
  assign hdr_b[0] = addr_i;
  assign hdr_b[1] = len_i[15:8];
  assign hdr_b[2] = len_i[7:0];
  assign hc[0]    = SYNC_CRC;

  // Data CRC: four stages, each bypassed once the byte lies beyond len.
  logic [7:0] db   [4];
  logic [7:0] dc_o [4];
  logic [7:0] dc   [5];
  assign dc[0] = crc_q;

  for (genvar g = 0; g < 3; g++) begin : g_hcrc
    crc8_ccitt u_hcrc (.crc_in(hc[g]), .din(hdr_b[g]), .crc_out(hc[g+1]));
  end

  for (genvar g = 0; g < 4; g++) begin : g_dcrc
    assign db[g] = dat_i[31-8*g -: 8];
    crc8_ccitt u_dcrc (.crc_in(dc[g]), .din(db[g]), .crc_out(dc_o[g]));
    assign dc[g+1] = (rem > LEN_W'(g)) ? dc_o[g] : dc[g];
  end

  logic        out_free, take, last_w, start_ok, start_bad;
  logic [7:0]  dcrc_nxt, dcrc_q;
  logic [31:0] body_w, tail_w;

  assign out_free  = !op_o || op_rdy_i;
  assign dat_rdy_o = (state == BODY) && (rem != '0) && out_free;
  assign take      = dat_rdy_o && dat_vld_i;
  assign last_w    = rem <= LEN_W'(4);
  assign start_ok  = (state == IDLE) && start_i && (len_i <= MAX_LEN);
  assign start_bad = (state == IDLE) && start_i && (len_i > MAX_LEN);
  assign dcrc_nxt  = dc[4] ^ {8{inj_q}};
  assign dcrc_q    = crc_q ^ {8{inj_q}};
  assign busy_o    = state != IDLE;
  assign done_o    = (state == DONE) && op_o && op_rdy_i;

  // A single trailing payload byte leaves room for dcrc in the same word.
  assign body_w = (rem == LEN_W'(1)) ? {carry, db[0], dcrc_nxt} : {carry, db[0], db[1]};

  // Tail flush: leftover carry bytes, then dcrc, zero padded.
  always_comb begin
    tail_w = {dcrc_q, 24'h0};
    case (ncarry)
      2'd2:    tail_w = {carry, dcrc_q, 8'h00};
      2'd1:    tail_w = {carry[15:8], dcrc_q, 16'h0};
      default: ;
    endcase
  end

`ifdef USB_ENC_CRC_INJ_EN
  // Injection flag is frozen for the whole frame.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)        inj_q <= 1'b0;
    else if (start_ok) inj_q <= crc_inj_i;
`else
  assign inj_q = 1'b0;
`endif

  // Framer FSM plus the output register, which only moves when it is free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      op_o     <= 1'b0;
      op_dat_o <= '0;
      op_be_o  <= '0;
      err_o    <= 1'b0;
      carry    <= '0;
      ncarry   <= '0;
      crc_q    <= CRC_INIT;
      rem      <= '0;
    end else begin
      err_o <= start_bad;
      case (state)
        IDLE: if (start_ok) begin
          state    <= HDR;
          op_o     <= 1'b1;
          op_dat_o <= {SYNC0, SYNC1, addr_i, len_i[15:8]};
          op_be_o  <= 3'd4;
          carry    <= {len_i[7:0], hc[3]};
          ncarry   <= 2'd2;
          crc_q    <= CRC_INIT;
          rem      <= len_i;
        end
        HDR: if (op_rdy_i) begin
          op_o  <= 1'b0;
          state <= (rem == '0) ? TAIL : BODY;
        end
        BODY: begin
          if (take) begin
            op_o     <= 1'b1;
            op_dat_o <= body_w;
            op_be_o  <= 3'd4;
            crc_q    <= dc[4];
            carry    <= {db[2], db[3]};
            rem      <= last_w ? '0 : rem - LEN_W'(4);
            if (last_w) begin
              ncarry <= rem[1:0] - 2'd2;
              state  <= (rem == LEN_W'(1)) ? DONE : TAIL;
            end
          end else if (op_rdy_i) begin
            op_o <= 1'b0;
          end
        end
        TAIL: if (out_free) begin
          op_o     <= 1'b1;
          op_dat_o <= tail_w;
          op_be_o  <= {1'b0, ncarry} + 3'd1;
          state    <= DONE;
        end
        DONE: if (op_rdy_i) begin
          op_o  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_prot_encoder.sv
// Scoreboard bench for usb_prot_encoder: byte-level frame model, monitor pops on handshake.
`timescale 1ns/1ps
module tb_usb_prot_encoder;

`ifdef USB_ENC_CRC_INJ_EN
  localparam bit HAS_INJ = 1'b1;
`else
  localparam bit HAS_INJ = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, start_i, dat_vld_i, dat_rdy_o, op_o, op_rdy_i;
  logic        busy_o, done_o, err_o, crc_inj;
  logic [7:0]  addr_i;
  logic [15:0] len_i;
  logic [31:0] dat_i, op_dat_o;
  logic [2:0]  op_be_o;

  always #5 clk = ~clk;

  usb_prot_encoder dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .addr_i(addr_i), .len_i(len_i),
    .dat_i(dat_i), .dat_vld_i(dat_vld_i), .dat_rdy_o(dat_rdy_o),
    .op_o(op_o), .op_dat_o(op_dat_o), .op_be_o(op_be_o), .op_rdy_i(op_rdy_i),
`ifdef USB_ENC_CRC_INJ_EN
    .crc_inj_i(crc_inj),
`endif
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  typedef struct {
    logic [31:0] dat;
    logic [2:0]  be;
    bit          last;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] pay_q[$];
  int          n_chk = 0, n_pass = 0, err_cnt = 0, rdy_mode = 0;
  bit          rdy_seen = 0;

  task automatic check(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  // Reference CRC, bit-serial definition.
  function automatic logic [7:0] crc_ref(input logic [7:0] c, input logic [7:0] b);
    logic [7:0] r;
    logic       fb;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      fb = r[7] ^ b[i];
      r  = {r[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return r;
  endfunction

  // Build the byte stream of a frame and cut it into expected output words.
  task automatic push_frame(input logic [7:0] a, input logic [15:0] l, input bit inj);
    logic [7:0] fb[$];
    logic [7:0] h, d, b;
    exp_t       e;
    int         n;
    fb = '{8'h5E, 8'h4D, a, l[15:8], l[7:0]};
    h = 8'h00;
    foreach (fb[i]) h = crc_ref(h, fb[i]);
    fb.push_back(h);
    d = 8'h00;
    for (int k = 0; k < int'(l); k++) begin
      b = 8'(pay_q[k/4] >> (24 - 8*(k%4)));
      d = crc_ref(d, b);
      fb.push_back(b);
    end
    fb.push_back((inj && HAS_INJ) ? ~d : d);
    n = fb.size();
    for (int w = 0; w*4 < n; w++) begin
      e.dat = '0;
      e.be  = 3'(((n - 4*w) > 4) ? 4 : (n - 4*w));
      for (int j = 0; j < 4; j++)
        if (4*w + j < n) e.dat[31-8*j -: 8] = fb[4*w + j];
      e.last = (4*w + 4 >= n);
      exp_q.push_back(e);
    end
  endtask

  // Downstream ready pattern: always, alternating, or random.
  initial begin
    op_rdy_i = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       op_rdy_i = 1'b1;
        1:       op_rdy_i = ~op_rdy_i;
        default: op_rdy_i = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: compares every accepted word and checks stability while stalled.
  initial begin
    exp_t        e;
    bit          hold = 0;
    logic [31:0] h_dat;
    logic [2:0]  h_be;
    forever begin
      @(negedge clk);
      if (!rst_n) begin hold = 0; continue; end
      if (dat_rdy_o) rdy_seen = 1;
      if (err_o) err_cnt++;
      if (hold)
        check(op_o && op_dat_o == h_dat && op_be_o == h_be, "stall_stable",
              {op_be_o, op_dat_o}, {h_be, h_dat});
      hold = 0;
      if (op_o) begin
        if (op_rdy_i) begin
          if (exp_q.size() == 0) check(0, "unexpected_word", {op_be_o, op_dat_o}, 0);
          else begin
            e = exp_q.pop_front();
            check(op_dat_o == e.dat && op_be_o == e.be, "word", {op_be_o, op_dat_o}, {e.be, e.dat});
            check(done_o == e.last, "done_pulse", done_o, e.last);
          end
        end else begin
          hold = 1; h_dat = op_dat_o; h_be = op_be_o;
        end
      end
    end
  end

  task automatic run_frame(input logic [7:0] a, input logic [15:0] l, input bit gaps, input bit inj,
                           input int abort_after, input bit poke, input bit use_p0, input logic [31:0] p0);
    int nw, i, guard;
    bit acc;
    nw = (int'(l) + 3) / 4;
    pay_q.delete();
    for (int k = 0; k < nw; k++) pay_q.push_back($urandom);
    if (use_p0 && nw > 0) pay_q[0] = p0;
    push_frame(a, l, inj);
    @(posedge clk); #1;
    start_i = 1'b1; addr_i = a; len_i = l; crc_inj = inj;
    @(posedge clk); #1;
    start_i = 1'b0; len_i = 16'($urandom);
    check(op_o == 1'b1, "hdr_latency", op_o, 1);
    i = 0; guard = 0;
    while (i < nw && guard < 5000) begin
      dat_i = pay_q[i];
      dat_vld_i = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      if (poke && i == 1) begin
        start_i = 1'b1; len_i = ($urandom_range(0, 1) != 0) ? 16'd3 : 16'd5000;
      end else start_i = 1'b0;
      @(negedge clk);
      acc = dat_vld_i && dat_rdy_o;
      @(posedge clk); #1;
      guard++;
      if (acc) i++;
      if (abort_after > 0 && i == abort_after) begin
        #2 rst_n = 1'b0;
        #1 check(!op_o && !busy_o && !dat_rdy_o, "abort_clear", {op_o, busy_o, dat_rdy_o}, 0);
        exp_q.delete();
        dat_vld_i = 1'b0; start_i = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        return;
      end
    end
    dat_vld_i = 1'b0; start_i = 1'b0;
    if (guard >= 5000) check(0, "payload_timeout", i, nw);
    guard = 0;
    while ((exp_q.size() != 0 || busy_o) && guard < 500) begin
      @(negedge clk); guard++;
    end
    check(exp_q.size() == 0, "frame_drain", exp_q.size(), 0);
    check(!busy_o, "busy_drop", busy_o, 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int l;
    rst_n = 1'b0; start_i = 1'b0; addr_i = '0; len_i = '0; dat_i = '0;
    dat_vld_i = 1'b0; crc_inj = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check({op_o, dat_rdy_o, busy_o, done_o, err_o, op_be_o, op_dat_o} == '0, "reset_state",
          {op_o, dat_rdy_o, busy_o, done_o, err_o, op_be_o, op_dat_o}, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Directed frames.
    rdy_mode = 0;
    run_frame(8'h01, 16'd1, 0, 0, 0, 0, 1, 32'h01A5C3F0);
    run_frame(8'h01, 16'd4, 0, 0, 0, 0, 1, 32'h00000000);
    rdy_seen = 0;
    run_frame(8'h01, 16'd0, 0, 0, 0, 0, 0, 32'h0);
    check(!rdy_seen, "len0_no_rdy", rdy_seen, 0);
    rdy_mode = 1;
    run_frame(8'h5A, 16'd9, 1, 0, 0, 1, 0, 32'h0);

    // Oversize start is rejected with a single err pulse.
    rdy_mode = 0;
    @(posedge clk); #1 start_i = 1'b1; len_i = 16'd4097;
    @(posedge clk); #1 start_i = 1'b0;
    @(negedge clk);
    check(err_o && !op_o, "err_pulse", {err_o, op_o}, 2'b10);
    @(negedge clk);
    check(!err_o && !op_o && !busy_o, "err_clear", {err_o, op_o, busy_o}, 0);

    // Largest legal frame.
    run_frame(8'hC3, 16'd4096, 0, 0, 0, 0, 0, 32'h0);

    // Abort mid-body, then a clean frame.
    rdy_mode = 2;
    run_frame(8'h22, 16'd40, 1, 0, 3, 0, 0, 32'h0);
    run_frame(8'h33, 16'd13, 1, 0, 0, 0, 0, 32'h0);

    if (HAS_INJ) begin
      rdy_mode = 0;
      run_frame(8'h01, 16'd1, 0, 1, 0, 0, 1, 32'h01000000);
    end

    // Random frames.
    for (int t = 0; t < 15; t++) begin
      l = $urandom_range(0, 37);
      rdy_mode = $urandom_range(0, 2);
      run_frame(8'($urandom), 16'(l), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0,
                (l > 4) && ($urandom_range(0, 1) != 0), 0, 32'h0);
    end

    check(err_cnt == 1, "err_count", err_cnt, 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
